// File: rtl/hmm_viterbi_multi_if.sv
// Bundle of config, emission-stream and result signals for the multi-HMM Viterbi scorer.
// master = controller/front-end side, slave = scorer side.
interface hmm_viterbi_multi_if #(
  parameter int N_HMM = 3,
  parameter int DW    = 32,
  parameter int TW    = 16,
  parameter int SW    = 40
);
  logic                      cfg_we;
  logic [2:0]                cfg_hmm;
  logic [3:0]                cfg_state;
  logic                      cfg_next;
  logic signed [TW-1:0]      cfg_data;
  logic                      start;
  logic                      in_valid;
  logic                      in_ready;
  logic [N_HMM*DW-1:0]       in_data;
  logic                      in_last;
  logic                      busy;
  logic                      out_valid;
  logic                      out_ready;
  logic [2:0]                out_idx;
  logic signed [SW-1:0]      out_score;
  logic [1:0]                state_dbg;

  modport master (
    output cfg_we, cfg_hmm, cfg_state, cfg_next, cfg_data, start,
           in_valid, in_data, in_last, out_ready,
    input  in_ready, busy, out_valid, out_idx, out_score, state_dbg
  );

  modport slave (
    input  cfg_we, cfg_hmm, cfg_state, cfg_next, cfg_data, start,
           in_valid, in_data, in_last, out_ready,
    output in_ready, busy, out_valid, out_idx, out_score, state_dbg
  );
endinterface

// File: rtl/hmm_viterbi_multi.sv
// Log-domain Viterbi scorer for N_HMM left-to-right HMMs run in parallel, one state-beat per
// accepted emission; at end of utterance reports the HMM with the best final-state score.
module hmm_viterbi_multi #(
  parameter int N_HMM      = 3,
  parameter int STATE      = 5,
  parameter int MAX_FRAMES = 32,
  parameter int DW         = 32,
  parameter int TW         = 16,
  parameter int SW         = 40
) (
  input  logic             clk,
  input  logic             reset,
  hmm_viterbi_multi_if.slave bus
);

  localparam int SCW = (STATE > 1) ? $clog2(STATE) : 1;
  localparam int TCW = $clog2(MAX_FRAMES + 1);
  localparam logic signed [SW-1:0] NEG_INF = {1'b1, {(SW-1){1'b0}}};
  localparam logic signed [SW-1:0] POS_MAX = {1'b0, {(SW-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DECIDE = 2'd2,
    OUT    = 2'd3
  } state_t;

  state_t state, state_next;

  logic [SCW-1:0]       s_cnt;
  logic [TCW-1:0]       t_cnt;
  logic [2:0]           d_cnt;
  logic signed [SW-1:0] best_score;
  logic [2:0]           best_idx;
  logic                 out_valid_q;
  logic [2:0]           out_idx_q;
  logic signed [SW-1:0] out_score_q;

  logic signed [TW-1:0] a_self [N_HMM][STATE];
  logic signed [TW-1:0] a_next [N_HMM][STATE];
  logic signed [SW-1:0] delta  [N_HMM][STATE];
  logic signed [SW-1:0] prev_d [N_HMM];

  logic signed [SW-1:0] cur_d  [N_HMM];
  logic signed [TW-1:0] as_v   [N_HMM];
  logic signed [TW-1:0] an_v   [N_HMM];
  logic signed [SW-1:0] x_v    [N_HMM];
  logic signed [SW-1:0] c_self [N_HMM];
  logic signed [SW-1:0] c_next [N_HMM];
  logic signed [SW-1:0] new_d  [N_HMM];
  logic signed [SW-1:0] fin_sel;

  logic beat, last_state, last_frame;

  // NEG_INF is absorbing (an unreachable state stays unreachable); otherwise clamp to range.
  function automatic logic signed [SW-1:0] sat_add(input logic signed [SW-1:0] a,
                                                   input logic signed [SW-1:0] b);
    logic signed [SW:0] sum;
    if (a == NEG_INF) return NEG_INF;
    sum = {a[SW-1], a} + {b[SW-1], b};
    if (sum[SW] != sum[SW-1]) return sum[SW] ? NEG_INF : POS_MAX;
    return sum[SW-1:0];
  endfunction

  function automatic logic signed [SW-1:0] ext_x(input logic [DW-1:0] v);
    return {{(SW-DW){v[DW-1]}}, v};
  endfunction

  function automatic logic signed [SW-1:0] ext_a(input logic [TW-1:0] v);
    return {{(SW-TW){v[TW-1]}}, v};
  endfunction

  // Emission stream: a beat transfers on a rising clk when in_valid && in_ready; in_valid may
  // be held low to stall, in_ready is high only in ACCUM, and in_last is sampled on the last
  // state beat of a frame only.
  assign beat       = (state == ACCUM) && bus.in_valid;
  assign last_state = (s_cnt == SCW'(STATE - 1));
  assign last_frame = bus.in_last || (t_cnt == TCW'(MAX_FRAMES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = ACCUM;
      ACCUM:   if (beat && last_state && last_frame) state_next = DECIDE;
      DECIDE:  if (d_cnt == 3'(N_HMM - 1)) state_next = OUT;
      OUT:     if (out_valid_q && bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == ACCUM);
    bus.busy      = (state != IDLE);
    bus.state_dbg = state;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_score = out_score_q;

  // Per-HMM recursion for the state addressed by s_cnt.
  always_comb begin
    for (int h = 0; h < N_HMM; h++) begin
      cur_d[h] = NEG_INF;
      as_v[h]  = '0;
      an_v[h]  = '0;
      for (int s = 0; s < STATE; s++) begin
        if (s_cnt == SCW'(s)) begin
          cur_d[h] = delta[h][s];
          as_v[h]  = a_self[h][s];
          an_v[h]  = a_next[h][s];
        end
      end
      x_v[h]    = ext_x(bus.in_data[h*DW +: DW]);
      c_self[h] = sat_add(cur_d[h], ext_a(as_v[h]));
      c_next[h] = sat_add(prev_d[h], ext_a(an_v[h]));
      if (t_cnt == '0)
        new_d[h] = (s_cnt == '0) ? x_v[h] : NEG_INF;
      else if (s_cnt == '0)
        new_d[h] = sat_add(c_self[h], x_v[h]);
      else
        new_d[h] = sat_add((c_self[h] >= c_next[h]) ? c_self[h] : c_next[h], x_v[h]);
    end
  end

  always_comb begin
    fin_sel = delta[0][STATE-1];
    for (int h = 0; h < N_HMM; h++)
      if (d_cnt == 3'(h)) fin_sel = delta[h][STATE-1];
  end

  // Path metrics are not reset: IDLE re-initialises them before any utterance uses them.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      for (int h = 0; h < N_HMM; h++) begin
        prev_d[h] <= NEG_INF;
        for (int s = 0; s < STATE; s++) delta[h][s] <= NEG_INF;
      end
    end else if (beat) begin
      for (int h = 0; h < N_HMM; h++) begin
        prev_d[h] <= cur_d[h];
        for (int s = 0; s < STATE; s++)
          if (s_cnt == SCW'(s)) delta[h][s] <= new_d[h];
      end
    end
  end

  // Transition tables survive reset; writes land only while idle and out-of-range targets miss.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.cfg_we) begin
      for (int h = 0; h < N_HMM; h++) begin
        for (int s = 0; s < STATE; s++) begin
          if (bus.cfg_hmm == 3'(h) && bus.cfg_state == 4'(s)) begin
            if (!bus.cfg_next)  a_self[h][s] <= bus.cfg_data;
            else if (s != 0)    a_next[h][s] <= bus.cfg_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_cnt       <= '0;
      t_cnt       <= '0;
      d_cnt       <= '0;
      best_score  <= '0;
      best_idx    <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_score_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          s_cnt <= '0;
          t_cnt <= '0;
          d_cnt <= '0;
        end
        ACCUM: begin
          d_cnt <= '0;
          if (beat) begin
            if (last_state) begin
              s_cnt <= '0;
              t_cnt <= t_cnt + 1'b1;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        DECIDE: begin
          d_cnt <= d_cnt + 1'b1;
          // Strictly-greater keeps the lowest index on ties.
          if (d_cnt == '0 || fin_sel > best_score) begin
            best_score <= fin_sel;
            best_idx   <= d_cnt;
          end
        end
        OUT: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_idx_q   <= best_idx;
            out_score_q <= best_score;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hmm_viterbi_multi.sv
// Directed bench for hmm_viterbi_multi: hand-computed scores, tie-break, latency,
// frame-limit termination, saturation, reset abandon and busy-time config writes.
module tb_hmm_viterbi_multi;

  localparam int N_HMM      = 3;
  localparam int STATE      = 5;
  localparam int MAX_FRAMES = 32;
  localparam int DW         = 32;
  localparam int TW         = 16;
  // Narrow accumulator so 32 frames of the maximum emission really hit the positive clamp.
  localparam int SW         = 34;
  localparam logic signed [SW-1:0] NEG_INF = {1'b1, {(SW-1){1'b0}}};
  localparam logic signed [SW-1:0] POS_MAX = {1'b0, {(SW-1){1'b1}}};
  localparam logic signed [DW-1:0] X_MAX   = {1'b0, {(DW-1){1'b1}}};

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   cnt;

  always #5 clk = ~clk;

  hmm_viterbi_multi_if #(.N_HMM(N_HMM), .DW(DW), .TW(TW), .SW(SW)) bus ();

  hmm_viterbi_multi #(
    .N_HMM(N_HMM), .STATE(STATE), .MAX_FRAMES(MAX_FRAMES), .DW(DW), .TW(TW), .SW(SW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input int h, input int s, input logic nxt, input logic signed [TW-1:0] d);
    bus.cfg_hmm   = 3'(h);
    bus.cfg_state = 4'(s);
    bus.cfg_next  = nxt;
    bus.cfg_data  = d;
    bus.cfg_we    = 1'b1;
    @(negedge clk);
    bus.cfg_we    = 1'b0;
  endtask

  task automatic start_utt();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_beat(input logic signed [DW-1:0] x0, x1, x2, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = {x2, x1, x0};
    bus.in_last  = last;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("beat_ready_timeout", {63'b0, bus.in_ready}, 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic signed [DW-1:0] x0, x1, x2, input logic last);
    for (int s = 0; s < STATE; s++) send_beat(x0, x1, x2, last && (s == STATE - 1));
  endtask

  task automatic get_result(input string tag, input int exp_idx, input logic signed [SW-1:0] exp_score);
    int n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {63'b0, bus.out_valid}, 64'd1);
    chk({tag, "_idx"}, {61'b0, bus.out_idx}, 64'(exp_idx));
    chk({tag, "_score"}, bus.out_score, exp_score);
    @(negedge clk);
    chk({tag, "_hold"}, bus.out_score, exp_score);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {63'b0, bus.out_valid}, 64'd0);
    chk({tag, "_idle"}, {63'b0, bus.busy}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_hmm   = '0;
    bus.cfg_state = '0;
    bus.cfg_next  = 1'b0;
    bus.cfg_data  = '0;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_in_ready", {63'b0, bus.in_ready}, 64'd0);
    chk("rst_busy", {63'b0, bus.busy}, 64'd0);
    chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("rst_out_idx", {61'b0, bus.out_idx}, 64'd0);
    chk("rst_out_score", bus.out_score, '0);
    chk("rst_state", {62'b0, bus.state_dbg}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int h = 0; h < N_HMM; h++)
      for (int s = 0; s < STATE; s++) begin
        cfg_write(h, s, 1'b0, 16'sd0);
        if (s > 0) cfg_write(h, s, 1'b1, 16'sd0);
      end

    // Two frames cannot reach state 4: every final score is NEG_INF, tie resolves to HMM0.
    start_utt();
    chk("t1_busy", {63'b0, bus.busy}, 64'd1);
    send_frame(32'sd10, 32'sd5, 32'sd1, 1'b0);
    send_frame(32'sd10, 32'sd5, 32'sd1, 1'b1);
    get_result("t1", 0, NEG_INF);

    // Five frames of ones: each final score is 5, tie to HMM0, result N_HMM+1 cycles after last beat.
    start_utt();
    for (int f = 0; f < 5; f++) send_frame(32'sd1, 32'sd1, 32'sd1, f == 4);
    chk("t2_in_ready_drop", {63'b0, bus.in_ready}, 64'd0);
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("t2_latency", 64'(cnt), 64'd4);
    get_result("t2", 0, 40'sd5);

    // No in_last: stops after 32 frames (160 beats); 32*(2^31-1) clamps at 2^33-1.
    start_utt();
    for (int f = 0; f < MAX_FRAMES; f++) send_frame(X_MAX, X_MAX, X_MAX, 1'b0);
    chk("t4_ready_drop", {63'b0, bus.in_ready}, 64'd0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t4_beat161_held", {63'b0, bus.in_ready}, 64'd0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    get_result("t4_sat", 0, POS_MAX);

    // HMM1 enter-transitions at -1: HMM0/HMM2 score 10, HMM1 score 6.
    for (int s = 1; s < STATE; s++) cfg_write(1, s, 1'b1, -16'sd1);
    start_utt();
    for (int f = 0; f < 5; f++) send_frame(32'sd2, 32'sd2, 32'sd2, f == 4);
    get_result("t3a", 0, 40'sd10);
    start_utt();
    for (int f = 0; f < 5; f++) send_frame(32'sd1, 32'sd2, 32'sd2, f == 4);
    get_result("t3b", 2, 40'sd10);

    // Abandon mid-frame-3 with reset; a config write made while busy must not stick.
    start_utt();
    send_frame(32'sd7, 32'sd7, 32'sd7, 1'b0);
    send_frame(32'sd7, 32'sd7, 32'sd7, 1'b0);
    for (int s = 0; s < 3; s++) send_beat(32'sd7, 32'sd7, 32'sd7, 1'b0);
    cfg_write(0, 1, 1'b1, -16'sd100);
    chk("t6_busy_mid", {63'b0, bus.busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", {63'b0, bus.busy}, 64'd0);
    chk("t6_rst_in_ready", {63'b0, bus.in_ready}, 64'd0);
    chk("t6_rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("t6_rst_out_idx", {61'b0, bus.out_idx}, 64'd0);
    chk("t6_rst_out_score", bus.out_score, '0);
    reset = 1'b0;
    @(negedge clk);
    start_utt();
    for (int f = 0; f < 5; f++) send_frame(32'sd3, 32'sd1, 32'sd2, f == 4);
    get_result("t6", 0, 40'sd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
